// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver.
//
// Oversamples the keyboard clock and data pins in the system clock domain.
// The keyboard clock is synchronised and glitch-filtered, and each filtered
// falling edge becomes a one-cycle sample event. Frames are deserialised
// (start, 8 data bits LSB first, odd parity, stop). The F0 break prefix and
// the E0 extended prefix are removed, and the last complete key code is
// presented on the outputs.
//
// Parameters:
//   FILTER_LEN  - consecutive identical synchronised PS2_CLK samples needed
//                 to change the filtered clock level (min 2)
//   TIMEOUT_CYC - CLK cycles without a sample event before a partial frame
//                 is abandoned
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   PS2_CLK   in   keyboard clock pin (asynchronous)
//   PS2_DATA  in   keyboard data pin (asynchronous)
//   scancode  out  last accepted key code (never F0 or E0)
//   flag      out  sticky, set once any key code has been accepted
//   code_strb out  one-cycle pulse when scancode is updated
//   brk       out  current scancode was preceded by F0 (key release)
//   err       out  one-cycle pulse on parity error, framing error or timeout

module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] scancode,
    output logic       flag,
    output logic       code_strb,
    output logic       brk,
    output logic       err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchroniser and filter state
    logic                  clkSync1_q, clkSync2_q;
    logic                  dataSync1_q, dataSync2_q;
    logic [FILTER_LEN-1:0] clkHist_q, clkHist_d;
    logic                  clkFilt_q, clkFilt_d;
    logic                  sampleEvt_q;
    logic                  dataCap_q;

    // Frame FSM and datapath state
    state_t                state_q, state_d;
    logic [2:0]            bitCnt_q, bitCnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [TO_W-1:0]       toCnt_q, toCnt_d;
    logic                  brkPend_q, brkPend_d;

    // Registered outputs
    logic [7:0]            scancode_q, scancode_d;
    logic                  flag_q, flag_d;
    logic                  strb_q, strb_d;
    logic                  brk_q, brk_d;
    logic                  err_q, err_d;

    logic                  frameOk;

    // The filter looks at the history including the sample arriving this
    // cycle, so exactly FILTER_LEN identical samples flip the level.
    always_comb begin
        clkHist_d = {clkHist_q[FILTER_LEN-2:0], clkSync2_q};
        clkFilt_d = clkFilt_q;
        if (clkHist_d == '0) begin
            clkFilt_d = 1'b0;
        end else if (clkHist_d == '1) begin
            clkFilt_d = 1'b1;
        end
    end

    // Pin synchronisers, glitch filter, and sample-event generation.
    // Data is captured on the same edge that raises the sample event, so the
    // FSM sees the bit that was present when the filtered clock fell.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clkSync1_q  <= 1'b1;
            clkSync2_q  <= 1'b1;
            dataSync1_q <= 1'b1;
            dataSync2_q <= 1'b1;
            clkHist_q   <= '1;
            clkFilt_q   <= 1'b1;
            sampleEvt_q <= 1'b0;
            dataCap_q   <= 1'b1;
        end else begin
            clkSync1_q  <= PS2_CLK;
            clkSync2_q  <= clkSync1_q;
            dataSync1_q <= PS2_DATA;
            dataSync2_q <= dataSync1_q;
            clkHist_q   <= clkHist_d;
            clkFilt_q   <= clkFilt_d;
            sampleEvt_q <= clkFilt_q & ~clkFilt_d;
            if (clkFilt_q & ~clkFilt_d) begin
                dataCap_q <= dataSync2_q;
            end
        end
    end

    // Stop bit must be 1 and the nine data+parity bits must have odd weight.
    assign frameOk = dataCap_q & ((^shift_q) ^ parity_q);

    // Next-state logic. A sample event always takes priority over the
    // timeout, so a bit arriving on the last allowed cycle is still processed.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        toCnt_d    = toCnt_q;
        brkPend_d  = brkPend_q;
        scancode_d = scancode_q;
        flag_d     = flag_q;
        brk_d      = brk_q;
        strb_d     = 1'b0;
        err_d      = 1'b0;

        if (state_q == IDLE || sampleEvt_q) begin
            toCnt_d = '0;
        end else begin
            toCnt_d = toCnt_q + 1'b1;
        end

        if (sampleEvt_q) begin
            case (state_q)
                IDLE: begin
                    if (!dataCap_q) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d[bitCnt_q] = dataCap_q;
                    bitCnt_d          = bitCnt_q + 1'b1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dataCap_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (frameOk) begin
                        if (shift_q == 8'hF0) begin
                            brkPend_d = 1'b1;
                        end else if (shift_q != 8'hE0) begin
                            scancode_d = shift_q;
                            brk_d      = brkPend_q;
                            brkPend_d  = 1'b0;
                            strb_d     = 1'b1;
                            flag_d     = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && toCnt_q == TO_MAX) begin
            err_d    = 1'b1;
            state_d  = IDLE;
            bitCnt_d = '0;
            toCnt_d  = '0;
        end
    end

    // FSM, datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            toCnt_q    <= '0;
            brkPend_q  <= 1'b0;
            scancode_q <= '0;
            flag_q     <= 1'b0;
            strb_q     <= 1'b0;
            brk_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            toCnt_q    <= toCnt_d;
            brkPend_q  <= brkPend_d;
            scancode_q <= scancode_d;
            flag_q     <= flag_d;
            strb_q     <= strb_d;
            brk_q      <= brk_d;
            err_q      <= err_d;
        end
    end

    assign scancode  = scancode_q;
    assign flag      = flag_q;
    assign code_strb = strb_q;
    assign brk       = brk_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed self-checking bench for ps2_rx.
// The keyboard clock is scaled down (HALF system cycles per half period) and
// the timeout is shortened so every scenario fits a short simulation.

module tb_ps2_rx;

    localparam int FILT    = 8;
    localparam int TOCYC   = 1000;
    localparam int HALF    = 20;

    logic       CLK;
    logic       RST_N;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [7:0] scancode;
    logic       flag;
    logic       code_strb;
    logic       brk;
    logic       err;

    int assertCount  = 0;
    int failCount    = 0;
    int strbCount    = 0;
    int errCount     = 0;
    int overlapCount = 0;
    int cycleCnt     = 0;
    int lastErrCycle = 0;

    ps2_rx #(
        .FILTER_LEN (FILT),
        .TIMEOUT_CYC(TOCYC)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .scancode (scancode),
        .flag     (flag),
        .code_strb(code_strb),
        .brk      (brk),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse monitor, sampled on the falling edge away from the active edge.
    always @(negedge CLK) begin
        cycleCnt++;
        if (RST_N) begin
            if (code_strb) strbCount++;
            if (err) begin
                errCount++;
                lastErrCycle = cycleCnt;
            end
            if (code_strb && err) overlapCount++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sendBit(input logic b);
        PS2_DATA = b;
        waitCycles(HALF);
        PS2_CLK = 1'b0;
        waitCycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    // Bit with a short low glitch in the middle of its clock-high phase.
    task automatic sendBitGlitchy(input logic b);
        PS2_DATA = b;
        waitCycles(8);
        PS2_CLK = 1'b0;
        waitCycles(3);
        PS2_CLK = 1'b1;
        waitCycles(HALF - 11);
        PS2_CLK = 1'b0;
        waitCycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic badParity, input logic glitchy);
        logic p;
        p = ~(^d);
        if (badParity) p = ~p;
        if (glitchy) begin
            sendBitGlitchy(1'b0);
            for (int i = 0; i < 8; i++) sendBitGlitchy(d[i]);
            sendBitGlitchy(p);
            sendBitGlitchy(1'b1);
        end else begin
            sendBit(1'b0);
            for (int i = 0; i < 8; i++) sendBit(d[i]);
            sendBit(p);
            sendBit(1'b1);
        end
        PS2_DATA = 1'b1;
        waitCycles(40);
    endtask

    task automatic test_reset;
        RST_N    = 1'b0;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        waitCycles(3);
        assertCount++;
        if (scancode !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_scancode: got %h expected %h", scancode, 8'h00);
        end
        assertCount++;
        if (flag !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flag: got %b expected 0", flag);
        end
        assertCount++;
        if ({code_strb, brk, err} !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL reset_pulses: got %b expected 000", {code_strb, brk, err});
        end
        RST_N = 1'b1;
        waitCycles(20);
    endtask

    task automatic test_single_code;
        int s0, e0;
        s0 = strbCount;
        e0 = errCount;
        sendFrame(8'h1D, 1'b0, 1'b0);
        assertCount++;
        if (strbCount - s0 !== 1) begin
            failCount++;
            $display("[TB] FAIL single_strb: got %0d expected 1", strbCount - s0);
        end
        assertCount++;
        if (scancode !== 8'h1D) begin
            failCount++;
            $display("[TB] FAIL single_scancode: got %h expected 1d", scancode);
        end
        assertCount++;
        if (flag !== 1'b1 || brk !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_flag_brk: got %b%b expected 10", flag, brk);
        end
        assertCount++;
        if (errCount - e0 !== 0) begin
            failCount++;
            $display("[TB] FAIL single_err: got %0d expected 0", errCount - e0);
        end
    endtask

    task automatic test_break;
        int s0, e0;
        s0 = strbCount;
        e0 = errCount;
        sendFrame(8'hF0, 1'b0, 1'b0);
        assertCount++;
        if (strbCount - s0 !== 0) begin
            failCount++;
            $display("[TB] FAIL break_f0_strb: got %0d expected 0", strbCount - s0);
        end
        sendFrame(8'h1D, 1'b0, 1'b0);
        assertCount++;
        if (strbCount - s0 !== 1 || scancode !== 8'h1D || brk !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL break_code: got strb %0d code %h brk %b expected 1 1d 1",
                     strbCount - s0, scancode, brk);
        end
        sendFrame(8'hE0, 1'b0, 1'b0);
        assertCount++;
        if (strbCount - s0 !== 1) begin
            failCount++;
            $display("[TB] FAIL break_e0_strb: got %0d expected 1", strbCount - s0);
        end
        sendFrame(8'h75, 1'b0, 1'b0);
        assertCount++;
        if (strbCount - s0 !== 2 || scancode !== 8'h75 || brk !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ext_code: got strb %0d code %h brk %b expected 2 75 0",
                     strbCount - s0, scancode, brk);
        end
        assertCount++;
        if (errCount - e0 !== 0) begin
            failCount++;
            $display("[TB] FAIL break_err: got %0d expected 0", errCount - e0);
        end
    endtask

    task automatic test_parity_error;
        int s0, e0;
        s0 = strbCount;
        e0 = errCount;
        sendFrame(8'h1D, 1'b1, 1'b0);
        assertCount++;
        if (errCount - e0 !== 1) begin
            failCount++;
            $display("[TB] FAIL parity_err: got %0d expected 1", errCount - e0);
        end
        assertCount++;
        if (strbCount - s0 !== 0) begin
            failCount++;
            $display("[TB] FAIL parity_strb: got %0d expected 0", strbCount - s0);
        end
        assertCount++;
        if (scancode !== 8'h75 || flag !== 1'b1 || brk !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL parity_hold: got %h %b %b expected 75 1 0", scancode, flag, brk);
        end
    endtask

    task automatic test_timeout;
        int s0, e0, mark, elapsed;
        logic [7:0] d;
        d  = 8'h75;
        e0 = errCount;
        sendBit(1'b0);
        for (int i = 0; i < 5; i++) sendBit(d[i]);
        PS2_DATA = 1'b1;
        mark = cycleCnt;
        waitCycles(1500);
        elapsed = lastErrCycle - mark;
        assertCount++;
        if (errCount - e0 !== 1) begin
            failCount++;
            $display("[TB] FAIL timeout_err: got %0d expected 1", errCount - e0);
        end
        assertCount++;
        if (elapsed < 970 || elapsed > 1010) begin
            failCount++;
            $display("[TB] FAIL timeout_time: got %0d cycles expected 970..1010", elapsed);
        end
        s0 = strbCount;
        e0 = errCount;
        sendFrame(8'h75, 1'b0, 1'b0);
        assertCount++;
        if (strbCount - s0 !== 1 || scancode !== 8'h75 || errCount - e0 !== 0) begin
            failCount++;
            $display("[TB] FAIL timeout_recover: got strb %0d code %h err %0d expected 1 75 0",
                     strbCount - s0, scancode, errCount - e0);
        end
    endtask

    task automatic test_glitch;
        int s0, e0;
        s0 = strbCount;
        e0 = errCount;
        // A glitch with data low would look like a start bit and end in a timeout.
        PS2_DATA = 1'b0;
        waitCycles(10);
        PS2_CLK = 1'b0;
        waitCycles(3);
        PS2_CLK = 1'b1;
        waitCycles(10);
        PS2_DATA = 1'b1;
        waitCycles(1200);
        assertCount++;
        if (errCount - e0 !== 0 || strbCount - s0 !== 0) begin
            failCount++;
            $display("[TB] FAIL glitch_idle: got err %0d strb %0d expected 0 0",
                     errCount - e0, strbCount - s0);
        end
        sendFrame(8'h6B, 1'b0, 1'b1);
        assertCount++;
        if (strbCount - s0 !== 1 || scancode !== 8'h6B || brk !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL glitch_frame: got strb %0d code %h brk %b expected 1 6b 0",
                     strbCount - s0, scancode, brk);
        end
        assertCount++;
        if (errCount - e0 !== 0) begin
            failCount++;
            $display("[TB] FAIL glitch_err: got %0d expected 0", errCount - e0);
        end
    endtask

    task automatic test_reset_midframe;
        int s0, e0;
        sendFrame(8'h1D, 1'b0, 1'b0);
        assertCount++;
        if (scancode !== 8'h1D) begin
            failCount++;
            $display("[TB] FAIL midrst_pre: got %h expected 1d", scancode);
        end
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        PS2_DATA = 1'b1;
        waitCycles(HALF);
        PS2_CLK = 1'b0;
        waitCycles(15);
        #2;
        RST_N = 1'b0;
        #1;
        assertCount++;
        if (scancode !== 8'h00 || {flag, code_strb, brk, err} !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL midrst_async: got %h %b expected 00 0000",
                     scancode, {flag, code_strb, brk, err});
        end
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        waitCycles(20);
        RST_N = 1'b1;
        waitCycles(20);
        s0 = strbCount;
        e0 = errCount;
        sendFrame(8'h1B, 1'b0, 1'b0);
        assertCount++;
        if (strbCount - s0 !== 1 || scancode !== 8'h1B || flag !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midrst_frame: got strb %0d code %h flag %b expected 1 1b 1",
                     strbCount - s0, scancode, flag);
        end
        assertCount++;
        if (errCount - e0 !== 0) begin
            failCount++;
            $display("[TB] FAIL midrst_err: got %0d expected 0", errCount - e0);
        end
    endtask

    initial begin
        test_reset;
        test_single_code;
        test_break;
        test_parity_error;
        test_timeout;
        test_glitch;
        test_reset_midframe;
        assertCount++;
        if (overlapCount !== 0) begin
            failCount++;
            $display("[TB] FAIL strb_err_overlap: got %0d expected 0", overlapCount);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Receives frames from a PS/2 keyboard and produces the `scancode` byte and `flag` qualifier consumed by the seven-segment scancode display and the snake-game control logic.
- Oversamples the open-collector `PS2_CLK`/`PS2_DATA` lines in the system clock domain. Synchronises and glitch-filters `PS2_CLK`.
- Deserialises the 11-bit frame (start, 8 data LSB-first, odd parity, stop).
- Strips the F0 break and E0 extended prefixes and presents the last complete key code.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised `PS2_CLK` samples required to change the filtered clock level (min 2).
- TIMEOUT_CYC, 100000: CLK cycles without a sample event before a partial frame is abandoned (1 ms at 100 MHz).

Ports:
- CLK, input, 1: system clock, all logic on rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- PS2_CLK, input, 1: keyboard clock pin, asynchronous.
- PS2_DATA, input, 1: keyboard data pin, asynchronous.
- scancode, output, 8: last accepted key code (not F0, not E0).
- flag, output, 1: sticky; 1 once any key code has been accepted since reset.
- code_strb, output, 1: one-cycle pulse when `scancode` is updated.
- brk, output, 1: 1 if the current `scancode` was preceded by F0 (key release).
- err, output, 1: one-cycle pulse on parity error, framing error or timeout.

Behaviour:
- **Reset:**
  - On RST_N low, immediately: `scancode`=0x00, `flag`=0, `code_strb`=0, `brk`=0, `err`=0.
  - FSM=IDLE, bit count=0, shift register=0, break_pending=0, timeout count=0.
  - Synchronisers and filter history set to 1, filtered clock=1.
  - Reset mid-frame discards the partial frame; no `err` pulse.
- **Synchronisation and filter:**
  - Both pins pass through 2-FF synchronisers.
  - The filtered clock goes 1->0 only after FILTER_LEN consecutive synchronised 0 samples, and 0->1 only after FILTER_LEN consecutive 1s.
  - The sample event is a one-cycle pulse registered on the filtered 1->0 transition.
  - The synchronised `PS2_DATA` is captured in the same cycle as the sample event.
  - A `PS2_CLK` low pulse shorter than FILTER_LEN cycles produces no sample event.
- **FSM (advances only on sample events, except on timeout):**
  - IDLE: data=0 -> DATA with bit count=0. Data=1 -> stay in IDLE; no error.
  - DATA: shift data into bit [count], LSB first, and increment count. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: data=1 and (XOR of 8 data bits XOR parity bit)=1 -> accept the byte. Otherwise pulse `err` for 1 cycle and discard the byte. Either way -> IDLE.
- **Accepting a byte (outputs registered; update appears in the cycle after the stop-bit sample event):**
  - 0xF0: set break_pending=1. No output change, no strobe.
  - 0xE0: ignore. break_pending is unchanged.
  - Any other byte:
    - `scancode`<=byte, `brk`<=break_pending, break_pending<=0.
    - `code_strb`=1 for exactly 1 cycle, `flag`<=1.
  - `flag` is never cleared except by reset.
- **Timeout:**
  - In any state other than IDLE, the counter increments each cycle and clears on every sample event.
  - When the counter reaches TIMEOUT_CYC-1 with no event in that cycle: pulse `err`, go to IDLE, clear bit count.
  - Outputs and break_pending are unchanged.
  - The counter is held at 0 in IDLE.
  - If a sample event coincides with the timeout cycle, the event wins: no timeout, and the event is processed normally.
- **Latency:** a `PS2_CLK` pin falling edge yields a sample event 2+FILTER_LEN+1 CLK cycles later (±1 for sampling phase).
- **Output stability:** `scancode` and `brk` hold their values between strobes. `err` and `code_strb` are never high in the same cycle.

Test Plan:
1. Reset, then send frame 0x1D (bits 0,1,0,1,1,1,0,0,0, parity 1, stop 1) at 12.5 kHz -> exactly one `code_strb`; `scancode`=0x1D, `flag`=1, `brk`=0, `err` stays 0.
2. Send F0 then 1D -> no strobe after F0; one strobe after 1D with `scancode`=0x1D and `brk`=1. Then send E0 75 (0x75 parity 0) -> `scancode`=0x75, `brk`=0.
3. Send 0x1D with parity bit 0 -> one `err` pulse; `scancode`, `flag` and `brk` unchanged; no strobe.
4. Send start + 5 data bits, then hold `PS2_CLK` high for 150000 cycles -> one `err` pulse near cycle 100000 after the last edge. Then send a full 0x75 -> accepted normally.
5. With FILTER_LEN=8, inject 3-cycle low glitches on `PS2_CLK` in IDLE and mid-frame -> no sample events; a frame with glitches between bits still decodes correctly.
6. Assert RST_N low mid-frame after `scancode`=0x1D -> all outputs return to 0 asynchronously. After release, a full 0x1B frame yields `scancode`=0x1B with no `err`.
